// File: rtl/race_round_timer_pkg.sv
// round_pkg: shared state encoding and BCD helpers for the race round timer.
package round_pkg;
  typedef enum logic [1:0] {IDLE = 2'b00, COUNTDOWN = 2'b01, RUN = 2'b10, EXPIRED = 2'b11} state_t;
  function automatic logic [3:0] bcd_tens(int s);
    return 4'(s / 10);
  endfunction
  function automatic logic [3:0] bcd_ones(int s);
    return 4'(s % 10);
  endfunction
endpackage

// File: rtl/race_round_timer_if.sv
// race_round_timer_if: controller-side requests and timer status/HUD outputs.
interface race_round_timer_if;
  logic wait_for_start, title_screen, pause;
  logic timer_done, cars_enable, countdown_active, go_pulse;
  logic [1:0] countdown_value;
  logic [3:0] sec_tens, sec_ones;
  modport master(output wait_for_start, title_screen, pause,
                 input timer_done, cars_enable, countdown_active, go_pulse, countdown_value, sec_tens, sec_ones);
  modport slave(input wait_for_start, title_screen, pause,
                output timer_done, cars_enable, countdown_active, go_pulse, countdown_value, sec_tens, sec_ones);
endinterface

// File: rtl/race_round_timer_sec_tick_gen.sv
// sec_tick_gen: one-second prescaler, tick on the last cycle of each second.
module sec_tick_gen #(
  parameter int CLK_HZ = 65000000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic tick
);
  localparam int W = CLK_HZ > 1 ? $clog2(CLK_HZ) : 1;
  localparam logic [W-1:0] LAST = W'(CLK_HZ - 1);
  logic [W-1:0] cnt;
  assign tick = enable && cnt == LAST;
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt <= '0;
    else if (clear) cnt <= '0;
    else if (enable) cnt <= tick ? '0 : cnt + 1'b1;
endmodule

// File: rtl/race_round_timer.sv
// race_round_timer: pre-start countdown, BCD round timer and expiry for one race round.
module race_round_timer
  import round_pkg::*;
#(
  parameter int CLK_HZ        = 65000000,
  parameter int ROUND_SEC     = 60,
  parameter int COUNTDOWN_SEC = 3
) (
  input logic clk,
  input logic rst,
  race_round_timer_if.slave bus
);
  localparam logic [3:0] RT = bcd_tens(ROUND_SEC);
  localparam logic [3:0] RO = bcd_ones(ROUND_SEC);
  localparam logic [1:0] CD = 2'(COUNTDOWN_SEC);
  state_t state;
  logic tick;
  sec_tick_gen #(.CLK_HZ(CLK_HZ)) u_tick (
    .clk(clk),
    .rst(rst),
    .clear(bus.wait_for_start || bus.title_screen),
    .enable((state == COUNTDOWN || state == RUN) && !bus.pause),
    .tick(tick)
  );
  // Every output is a register updated alongside the state so all of them move together.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      bus.countdown_value <= 2'd0;
      bus.sec_tens <= RT;
      bus.sec_ones <= RO;
      bus.timer_done <= 1'b0;
      bus.cars_enable <= 1'b0;
      bus.countdown_active <= 1'b0;
      bus.go_pulse <= 1'b0;
    end else begin
      bus.go_pulse <= 1'b0;
      if (bus.wait_for_start) begin
        bus.sec_tens <= RT;
        bus.sec_ones <= RO;
        bus.timer_done <= 1'b0;
        bus.countdown_value <= CD;
        bus.countdown_active <= CD != 2'd0;
        bus.cars_enable <= CD == 2'd0;
        bus.go_pulse <= CD == 2'd0;
        state <= CD == 2'd0 ? RUN : COUNTDOWN;
      end else if (bus.title_screen) begin
        state <= IDLE;
        bus.sec_tens <= RT;
        bus.sec_ones <= RO;
        bus.countdown_value <= 2'd0;
        bus.timer_done <= 1'b0;
        bus.cars_enable <= 1'b0;
        bus.countdown_active <= 1'b0;
      end else if (tick && state == COUNTDOWN) begin
        bus.countdown_value <= bus.countdown_value - 2'd1;
        if (bus.countdown_value == 2'd1) begin
          state <= RUN;
          bus.countdown_active <= 1'b0;
          bus.cars_enable <= 1'b1;
          bus.go_pulse <= 1'b1;
        end
      end else if (tick && state == RUN) begin
        if (bus.sec_tens == 4'd0 && bus.sec_ones == 4'd1) begin
          state <= EXPIRED;
          bus.sec_ones <= 4'd0;
          bus.cars_enable <= 1'b0;
          bus.timer_done <= 1'b1;
        end else if (bus.sec_ones == 4'd0) begin
          bus.sec_ones <= 4'd9;
          bus.sec_tens <= bus.sec_tens - 4'd1;
        end else bus.sec_ones <= bus.sec_ones - 4'd1;
      end
    end
endmodule

// File: tb/tb_race_round_timer.sv
// tb_race_round_timer: cycle-budget model plus directed checks for the race round timer.
module tb_race_round_timer;
  localparam int C = 10, R = 12, CDS = 3;
  localparam int M_IDLE = 0, M_CD = 1, M_RUN = 2, M_EXP = 3;
  logic clk = 1'b0, rst = 1'b0;
  int checks = 0, errors = 0, now = 0;
  race_round_timer_if bus();
  race_round_timer_if bus0();
  race_round_timer #(.CLK_HZ(C), .ROUND_SEC(R), .COUNTDOWN_SEC(CDS)) dut (.clk(clk), .rst(rst), .bus(bus));
  race_round_timer #(.CLK_HZ(C), .ROUND_SEC(R), .COUNTDOWN_SEC(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  always #5 clk = ~clk;
  always @(posedge clk) now++;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: remaining cycle budgets for countdown and round; displays are their ceilings in seconds.
  int mode = M_IDLE, cd_left = 0, round_left = R * C;
  bit m_go = 0;
  always @(posedge clk or negedge rst)
    if (!rst) begin
      mode = M_IDLE; cd_left = 0; round_left = R * C; m_go = 0;
    end else begin
      m_go = 0;
      if (bus.wait_for_start) begin
        round_left = R * C;
        cd_left = CDS * C;
        mode = CDS == 0 ? M_RUN : M_CD;
        m_go = CDS == 0;
      end else if (bus.title_screen) begin
        mode = M_IDLE; round_left = R * C;
      end else if (!bus.pause) begin
        if (mode == M_CD) begin
          cd_left--;
          if (cd_left == 0) begin mode = M_RUN; m_go = 1; end
        end else if (mode == M_RUN) begin
          round_left--;
          if (round_left == 0) mode = M_EXP;
        end
      end
    end

  always @(negedge clk)
    if (rst) begin
      int secs;
      secs = (round_left + C - 1) / C;
      chk("m_timer_done", bus.timer_done, mode == M_EXP);
      chk("m_cars_enable", bus.cars_enable, mode == M_RUN);
      chk("m_countdown_active", bus.countdown_active, mode == M_CD);
      chk("m_countdown_value", bus.countdown_value, mode == M_CD ? (cd_left + C - 1) / C : 0);
      chk("m_go_pulse", bus.go_pulse, m_go);
      chk("m_sec_tens", bus.sec_tens, secs / 10);
      chk("m_sec_ones", bus.sec_ones, secs % 10);
    end

  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic pulse_start();
    bus.wait_for_start = 1'b1;
    @(negedge clk);
    bus.wait_for_start = 1'b0;
  endtask
  task automatic wait_go(output int k);
    k = 0;
    while (!bus.go_pulse && k < 200) begin @(negedge clk); k++; end
  endtask
  task automatic wait_sec(input int s);
    int k = 0;
    while (!(bus.sec_tens == 4'(s / 10) && bus.sec_ones == 4'(s % 10)) && k < 300) begin @(negedge clk); k++; end
    chk("reach_sec", k < 300, 1);
  endtask
  task automatic wait_done();
    int k = 0;
    while (!bus.timer_done && k < 400) begin @(negedge clk); k++; end
    chk("done_within_bound", k < 400, 1);
  endtask

  initial begin
    int k, t_go;
    {bus.wait_for_start, bus.title_screen, bus.pause} = 3'b000;
    {bus0.wait_for_start, bus0.title_screen, bus0.pause} = 3'b000;
    cyc(2);
    chk("rst_tens", bus.sec_tens, 1);
    chk("rst_ones", bus.sec_ones, 2);
    chk("rst_cv", bus.countdown_value, 0);
    chk("rst_bits", {bus.timer_done, bus.cars_enable, bus.countdown_active, bus.go_pulse}, 0);
    rst = 1'b1;
    cyc(2);
    pulse_start();
    chk("start_cv", bus.countdown_value, 3);
    chk("start_active", bus.countdown_active, 1);
    wait_go(k);
    chk("go_latency", k, 30);
    t_go = now;
    chk("go_cars", bus.cars_enable, 1);
    chk("go_sec", {bus.sec_tens, bus.sec_ones}, 8'h12);
    cyc(1);
    chk("go_one_cycle", bus.go_pulse, 0);
    wait_sec(10);
    cyc(10);
    chk("bcd_wrap_09", {bus.sec_tens, bus.sec_ones}, 8'h09);
    wait_done();
    chk("round_len", now - t_go, 120);
    chk("exp_sec", {bus.sec_tens, bus.sec_ones}, 8'h00);
    chk("exp_cars", bus.cars_enable, 0);
    cyc(5);
    chk("exp_hold", bus.timer_done, 1);
    pulse_start();
    chk("restart_done", bus.timer_done, 0);
    chk("restart_cv", bus.countdown_value, 3);
    chk("restart_sec", {bus.sec_tens, bus.sec_ones}, 8'h12);
    wait_go(k);
    chk("restart_go_latency", k, 30);
    t_go = now;
    wait_sec(7);
    bus.pause = 1'b1;
    cyc(25);
    bus.pause = 1'b0;
    chk("pause_hold_sec", {bus.sec_tens, bus.sec_ones}, 8'h07);
    wait_done();
    chk("paused_round_len", now - t_go, 145);
    pulse_start();
    wait_sec(5);
    bus.title_screen = 1'b1;
    @(negedge clk);
    bus.title_screen = 1'b0;
    chk("title_bits", {bus.timer_done, bus.cars_enable, bus.countdown_active, bus.go_pulse}, 0);
    chk("title_cv", bus.countdown_value, 0);
    chk("title_sec", {bus.sec_tens, bus.sec_ones}, 8'h12);
    bus.title_screen = 1'b1;
    bus.wait_for_start = 1'b1;
    @(negedge clk);
    {bus.title_screen, bus.wait_for_start} = 2'b00;
    chk("both_active", bus.countdown_active, 1);
    chk("both_cv", bus.countdown_value, 3);
    cyc(5);
    #2 rst = 1'b0;
    #1;
    chk("arst_active", bus.countdown_active, 0);
    chk("arst_cv", bus.countdown_value, 0);
    chk("arst_sec", {bus.sec_tens, bus.sec_ones}, 8'h12);
    @(negedge clk);
    rst = 1'b1;
    cyc(1);
    bus0.wait_for_start = 1'b1;
    @(negedge clk);
    bus0.wait_for_start = 1'b0;
    chk("cd0_go", bus0.go_pulse, 1);
    chk("cd0_cars", bus0.cars_enable, 1);
    chk("cd0_active", bus0.countdown_active, 0);
    chk("cd0_sec", {bus0.sec_tens, bus0.sec_ones}, 8'h12);
    cyc(1);
    chk("cd0_go_low", bus0.go_pulse, 0);
    cyc(9);
    chk("cd0_first_tick", {bus0.sec_tens, bus0.sec_ones}, 8'h11);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end
endmodule
